// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, baud-set codes and defaults shared by the UART TX path.
package uart_pkg;

   // Sequencer states; GAP is only reachable when inter-byte gaps are built in.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      SEND      = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } feeder_state_t;

   // Baud-set codes understood by the byte transmitter.
   localparam logic [2:0] BAUD_9600   = 3'd0;
   localparam logic [2:0] BAUD_19200  = 3'd1;
   localparam logic [2:0] BAUD_38400  = 3'd2;
   localparam logic [2:0] BAUD_57600  = 3'd3;
   localparam logic [2:0] BAUD_115200 = 3'd4;

   // One byte at 9600 baud from a 50 MHz clock is ~52k cycles; this leaves ample margin.
   localparam int DEFAULT_TIMEOUT_CYCLES = 2000000;
   localparam int DEFAULT_GAP_CYCLES     = 100;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: 8-bit synchronous FIFO with registered read data, count, full and empty.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
)(
   input  logic              clk,
   input  logic              rst_n_i,
   input  logic              wr_en_i,
   input  logic [7:0]        wr_data_i,
   input  logic              rd_en_i,
   output logic [7:0]        rd_data_o,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [7:0]        rd_data_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W:0]   count_q;
   logic              wr_fire;
   logic              rd_fire;

   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == '0);
   // A full FIFO refuses writes even when a read frees a slot in the same cycle.
   assign wr_fire   = wr_en_i && !full_o;
   assign rd_fire   = rd_en_i && !empty_o;
   assign rd_data_o = rd_data_q;
   assign count_o   = count_q;

   // Storage and registered read; no reset so it maps onto block RAM. Reads never hit the
   // slot being written because reads need non-empty and writes need non-full.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
      if (rd_fire) begin
         rd_data_q <= mem_q[rd_ptr_q];
      end
   end

   // Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_fire, rd_fire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and hands them one at a time to the UART byte
// transmitter (send_go pulse, wait for tx_done), with a WAIT_DONE watchdog.
// Optional inter-byte idle gap is compiled in with the macro UART_TX_GAP_EN.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int ADDR_W         = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES
)(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        tx_data,
   output logic              send_go,
   input  logic              tx_done,
   output logic [ADDR_W:0]   fifo_count,
   output logic              busy,
   output logic              timeout_err
);

   // Watchdog counts cycles elapsed since send_go; TIMEOUT_CYCLES must be at least 2.
   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   feeder_state_t   state_q, state_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [WD_W-1:0] wd_q, wd_d, wd_inc;
   logic            timeout_err_q, timeout_err_d;
   logic            rd_en;
   logic [7:0]      fifo_rd_data;
   logic            fifo_full;
   logic            fifo_empty;

`ifdef UART_TX_GAP_EN
   localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   logic [GAP_W-1:0] gap_q, gap_d;
`endif

   uart_sync_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk       (Clk),
      .rst_n_i   (Reset_n),
      .wr_en_i   (in_valid),
      .wr_data_i (in_data),
      .rd_en_i   (rd_en),
      .rd_data_o (fifo_rd_data),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign in_ready    = !fifo_full;
   assign busy        = (state_q != IDLE) || !fifo_empty;
   assign tx_data     = tx_data_q;
   assign timeout_err = timeout_err_q;
   assign wd_inc      = wd_q + 1'b1;

   // Sequencer state, held byte, watchdog and sticky error registers.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q       <= IDLE;
         tx_data_q     <= '0;
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
`ifdef UART_TX_GAP_EN
         gap_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         tx_data_q     <= tx_data_d;
         wd_q          <= wd_d;
         timeout_err_q <= timeout_err_d;
`ifdef UART_TX_GAP_EN
         gap_q         <= gap_d;
`endif
      end
   end

   // Next-state and output decode: IDLE -> LOAD -> SEND -> WAIT_DONE (-> GAP) -> IDLE.
   always_comb begin
      state_d       = state_q;
      tx_data_d     = tx_data_q;
      wd_d          = wd_q;
      timeout_err_d = timeout_err_q;
      rd_en         = 1'b0;
      send_go       = 1'b0;
`ifdef UART_TX_GAP_EN
      gap_d         = gap_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               rd_en   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            tx_data_d = fifo_rd_data;
            state_d   = SEND;
         end
         SEND: begin
            send_go = 1'b1;
            wd_d    = '0;
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            wd_d = wd_inc;
            if (tx_done) begin
`ifdef UART_TX_GAP_EN
               gap_d   = '0;
               state_d = GAP;
`else
               state_d = IDLE;
`endif
            end else if (wd_inc == WD_LAST) begin
               // Transmitter never answered: flag it and drop this byte.
               timeout_err_d = 1'b1;
               state_d       = IDLE;
            end
         end
`ifdef UART_TX_GAP_EN
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

endmodule
